fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Front-end controller for the 8-point FFT datapath.
- Collects an N-sample real frame from the sample stream into a local buffer, announces the frame to stage 1 with a one-cycle valid_packet pulse, then serves stage-1 requests one sample at a time in bit-reversed order.
- Holds off the next frame until the downstream pipeline signals done.
- Counts completed frames and samples dropped while busy.

Parameters:
- Q_IN, 15, MSB index of the sample word (width Q_IN+1, two's complement).
- N, 8, frame length; power of two, 2..16.
- LOG2N, 3, log2(N); sets the bit-reverse width and the address width used.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_in  in  Q_IN+1  signed input sample.
- req  in  1  stage-1 request for the next sample (stage 1 valid_request).
- done_in  in  1  downstream pipeline finished the current frame.
- valid_packet  out  1  one-cycle pulse: frame ready (to stage 1 valid_packet).
- valid_out  out  1  data_out/addr_out valid (to stage 1 valid_in).
- data_out  out  Q_IN+1  signed sample served.
- addr_out  out  4  natural-order serve index 0..N-1; upper bits 0.
- busy  out  1  high in every state except FILL.
- frame_count  out  8  completed frames, wraps 255->0.
- drop_count  out  8  samples dropped, saturates at 255.

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - All outputs go to 0. wr_ptr=0, rd_cnt=0, state=FILL.
  - The buffer contents are not cleared and are don't-care.
  - Reset mid-frame abandons the frame; there is no valid_out or valid_packet in the cycle after reset.
- States: FILL, ANNOUNCE, SERVE, WAIT_DONE.
- FILL:
  - Each cycle with sample_valid=1: buf[wr_ptr]<=sample_in, wr_ptr++.
  - On the accept with wr_ptr==N-1: wr_ptr<=0, state<=ANNOUNCE.
  - req and done_in are ignored.
- ANNOUNCE:
  - valid_packet=1 for exactly this one cycle, i.e. the cycle after the last sample is accepted. Then state<=SERVE.
  - A req in this cycle is ignored.
- SERVE:
  - req=1 sampled at an edge produces, in the following cycle: valid_out=1, data_out=buf[bitrev_LOG2N(rd_cnt)], addr_out=rd_cnt. rd_cnt increments on that edge.
  - Latency is 1 cycle. Back-to-back requests are allowed and give back-to-back responses.
  - valid_out is low in any cycle not following an accepted req. data_out and addr_out hold their last values when valid_out=0.
  - The req that makes rd_cnt==N-1 gets its response, and state<=WAIT_DONE with rd_cnt<=0.
- WAIT_DONE:
  - req is ignored; no extra valid_out.
  - done_in=1 -> state<=FILL, frame_count++.
  - done_in in any other state is ignored and does not increment frame_count.
- Drops: sample_valid=1 in any state other than FILL -> sample discarded, drop_count++ saturating at 255. Buffer and wr_ptr are unchanged.
- Bit-reverse: for N=8, the serve order is buf[0,4,2,6,1,5,3,7].
- Simultaneous events:
  - The last FILL sample in the same cycle as done_in: the sample is accepted; done_in is ignored.
  - In SERVE, sample_valid together with req: the sample is dropped and the req is served.
- busy=1 in ANNOUNCE, SERVE and WAIT_DONE, registered with the state.

Test Plan:
1. Reset, then sample_in=10..17 on 8 consecutive cycles -> valid_packet high for 1 cycle exactly 1 cycle after the 8th sample, busy=1, frame_count=0.
2. 8 single-cycle reqs spaced 3 cycles apart -> each valid_out 1 cycle after its req. data_out sequence is 10,14,12,16,11,15,13,17 with addr_out 0..7. No 9th response after a 9th req.
3. 8 back-to-back reqs -> 8 consecutive valid_out cycles with the same order. Then done_in=1 -> frame_count=1, busy=0 the next cycle. A second frame 20..27 serves as 20,24,22,26,21,25,23,27.
4. 5 samples applied during SERVE/WAIT_DONE -> drop_count=5, served data unchanged. 300 drops -> drop_count=255.
5. Reset asserted after 4 served samples -> all outputs 0 next cycle, state FILL. A new frame of 8 samples is required before valid_packet.
6. done_in pulses during FILL and during SERVE -> frame_count unchanged. req during FILL/ANNOUNCE -> no valid_out.

Source files
------------

// File: rtl/fft_frame_sequencer_if.sv
// Sample-stream, stage-1 request/response and status signals of the FFT front-end sequencer.
interface fft_frame_sequencer_if #(parameter int Q_IN = 15);
  logic                sample_valid;
  logic signed [Q_IN:0] sample_in;
  logic                req;
  logic                done_in;
  logic                valid_packet;
  logic                valid_out;
  logic signed [Q_IN:0] data_out;
  logic [3:0]          addr_out;
  logic                busy;
  logic [7:0]          frame_count;
  logic [7:0]          drop_count;

  modport master (
    output sample_valid, sample_in, req, done_in,
    input  valid_packet, valid_out, data_out, addr_out, busy, frame_count, drop_count
  );

  modport slave (
    input  sample_valid, sample_in, req, done_in,
    output valid_packet, valid_out, data_out, addr_out, busy, frame_count, drop_count
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Buffers an N-sample frame, announces it to stage 1, then serves it in bit-reversed
// order one sample per request (1-cycle latency); holds off new frames until done_in.
module fft_frame_sequencer #(
  parameter int Q_IN  = 15,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input logic                  clk,
  input logic                  reset,
  fft_frame_sequencer_if.slave io
);

  typedef enum logic [1:0] {FILL, ANNOUNCE, SERVE, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic signed [Q_IN:0] sample_buf [N];
  logic [LOG2N-1:0]     wr_ptr, rd_cnt;
  logic                 accept, serve, drop, last_wr, last_rd, frame_done;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    accept     = (state == FILL) && io.sample_valid;
    serve      = (state == SERVE) && io.req;
    drop       = (state != FILL) && io.sample_valid;
    frame_done = (state == WAIT_DONE) && io.done_in;
    last_wr    = (wr_ptr == LOG2N'(N-1));
    last_rd    = (rd_cnt == LOG2N'(N-1));
    state_nxt  = state;
    case (state)
      FILL:      if (accept && last_wr) state_nxt = ANNOUNCE;
      ANNOUNCE:  state_nxt = SERVE;
      SERVE:     if (serve && last_rd) state_nxt = WAIT_DONE;
      WAIT_DONE: if (io.done_in) state_nxt = FILL;
      default:   state_nxt = FILL;
    endcase
  end

  // Buffer contents survive reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) sample_buf[wr_ptr] <= io.sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_cnt         <= '0;
      io.valid_out   <= 1'b0;
      io.data_out    <= '0;
      io.addr_out    <= '0;
      io.frame_count <= '0;
      io.drop_count  <= '0;
    end else begin
      io.valid_out <= serve;
      if (accept) wr_ptr <= last_wr ? '0 : wr_ptr + LOG2N'(1);
      if (serve) begin
        io.data_out <= sample_buf[bitrev(rd_cnt)];
        io.addr_out <= 4'(rd_cnt);
        rd_cnt      <= last_rd ? '0 : rd_cnt + LOG2N'(1);
      end
      if (frame_done) io.frame_count <= io.frame_count + 8'd1;
      if (drop && io.drop_count != 8'hFF) io.drop_count <= io.drop_count + 8'd1;
    end
  end

  assign io.valid_packet = (state == ANNOUNCE);
  assign io.busy         = (state != FILL);

endmodule
